// File: rtl/delivery_controller_pkg.sv
// Shared definitions for the delivery controller and the game analyzer:
// FSM state encodings, screen geometry and delivery timing constants.
package delivery_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOWL   = 2'd1,
        FLIGHT = 2'd2,
        LAND   = 2'd3
    } state_t;

    // Ball start position and batting crease
    localparam logic [8:0] BOWL_X0 = 9'd160;
    localparam logic [7:0] BOWL_Y0 = 8'd20;
    localparam logic [7:0] BAT_Y   = 8'd200;

    // Swing window covers pixely in [BAT_Y-WIN, BAT_Y-1]
    localparam logic [7:0] WIN     = 8'd16;
    localparam logic [7:0] WIN_TOP = BAT_Y - WIN;

    // Post-hit flight
    localparam logic [4:0] FLIGHT_TICKS = 5'd8;
    localparam logic [7:0] FLIGHT_DY    = 8'd8;

    // Miss landing point, inside the analyzer OUT zone
    localparam logic [8:0] MISS_X = 9'd6;
    localparam logic [7:0] MISS_Y = 8'd200;

    // OUT zone box as read by the analyzer
    localparam logic [8:0] OUT_X_MIN = 9'd4;
    localparam logic [8:0] OUT_X_MAX = 9'd7;
    localparam logic [7:0] OUT_Y_MIN = 8'd175;
    localparam logic [7:0] OUT_Y_MAX = 8'd230;

    // Landing point hold time
    localparam logic [4:0] HOLD_TICKS = 5'd30;

    // Horizontal offset per flight tick from the ball height at swing time.
    // Only called with y inside the swing window, so the result fits 4 bits.
    function automatic logic [3:0] swing_offset(input logic [7:0] y);
        logic [7:0] d;
        d = BAT_Y - 8'd1 - y;
        return d[3:0];
    endfunction

    // Five-bit tick counter increment that sticks at its terminal value
    function automatic logic [4:0] sat_inc(input logic [4:0] c);
        return (c == 5'd31) ? c : c + 5'd1;
    endfunction

endpackage

// File: rtl/delivery_controller_rise_detect.sv
// Registered rising-edge detector for a pre-synchronised level input.
// Comes out of reset treating the input as already high, so a button held
// through reset must be released before it can fire.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev;

    // Remember last cycle's level
    always_ff @(posedge clock) begin
        if (reset) prev <= 1'b1;
        else       prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/delivery_controller.sv
// Bowls a delivery, animates the ball on frame ticks, opens the swing window
// and reports the landing point to the analyzer with throw/strike pulses.
module delivery_controller
    import delivery_controller_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       bowl_btn,
    input  logic       swing_btn,
    input  logic       game_over,
    output logic       throw,
    output logic       strike,
    output logic [8:0] pixelx,
    output logic [7:0] pixely,
    output logic       ball_visible,
    output logic       busy
);

    state_t     state, state_next;
    logic [8:0] x_next;
    logic [7:0] y_next;
    logic [3:0] offset, offset_next;
    logic [4:0] cnt, cnt_next;
    logic       swung_early, early_next;
    logic       struck;
    logic       bowl_rise, swing_rise;

    rise_detect u_bowl_edge (
        .clock (clock),
        .reset (reset),
        .level (bowl_btn),
        .rise  (bowl_rise)
    );

    rise_detect u_swing_edge (
        .clock (clock),
        .reset (reset),
        .level (swing_btn),
        .rise  (swing_rise)
    );

    // State, position, offset, counter and flag registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pixelx      <= BOWL_X0;
            pixely      <= BOWL_Y0;
            offset      <= 4'd0;
            cnt         <= 5'd0;
            swung_early <= 1'b0;
            struck      <= 1'b0;
        end else begin
            state       <= state_next;
            pixelx      <= x_next;
            pixely      <= y_next;
            offset      <= offset_next;
            cnt         <= cnt_next;
            swung_early <= early_next;
            struck      <= (state == LAND);
        end
    end

    // Next-state, datapath updates and throw pulse
    always_comb begin
        state_next  = state;
        x_next      = pixelx;
        y_next      = pixely;
        offset_next = offset;
        cnt_next    = cnt;
        early_next  = swung_early;
        throw       = 1'b0;

        case (state)
            IDLE: begin
                if (!game_over && bowl_rise) begin
                    throw      = 1'b1;
                    state_next = BOWL;
                    cnt_next   = 5'd0;
                    early_next = 1'b0;
                    x_next     = BOWL_X0;
                    y_next     = BOWL_Y0;
                end
            end

            BOWL: begin
                if (game_over) begin
                    state_next = IDLE;
                    x_next     = BOWL_X0;
                    y_next     = BOWL_Y0;
                end else if (swing_rise && !swung_early && pixely >= WIN_TOP) begin
                    // Hit: offset taken from the pre-move height; flight
                    // starts from the crease so the landing point depends
                    // only on the offset.
                    offset_next = swing_offset(pixely);
                    state_next  = FLIGHT;
                    cnt_next    = 5'd0;
                    x_next      = BOWL_X0;
                    y_next      = BAT_Y;
                end else begin
                    if (swing_rise && pixely < WIN_TOP)
                        early_next = 1'b1;
                    if (tick) begin
                        if (pixely == BAT_Y - 8'd1) begin
                            state_next = LAND;
                            cnt_next   = 5'd0;
                            x_next     = MISS_X;
                            y_next     = MISS_Y;
                        end else begin
                            y_next = pixely + 8'd1;
                        end
                    end
                end
            end

            FLIGHT: begin
                if (game_over) begin
                    state_next = IDLE;
                    x_next     = BOWL_X0;
                    y_next     = BOWL_Y0;
                end else if (tick) begin
                    x_next = pixelx - {5'd0, offset};
                    y_next = pixely - FLIGHT_DY;
                    if (cnt == FLIGHT_TICKS - 5'd1) begin
                        state_next = LAND;
                        cnt_next   = 5'd0;
                    end else begin
                        cnt_next = sat_inc(cnt);
                    end
                end
            end

            LAND: begin
                if (tick) begin
                    if (cnt == HOLD_TICKS - 5'd1) begin
                        state_next = IDLE;
                        cnt_next   = 5'd0;
                        x_next     = BOWL_X0;
                        y_next     = BOWL_Y0;
                    end else begin
                        cnt_next = sat_inc(cnt);
                    end
                end
            end

            default: begin
                state_next = IDLE;
                x_next     = BOWL_X0;
                y_next     = BOWL_Y0;
            end
        endcase
    end

    assign strike       = (state == LAND) && !struck;
    assign busy         = (state != IDLE);
    assign ball_visible = (state != IDLE);

endmodule

// File: tb/tb_delivery_controller.sv
// Directed bench for delivery_controller. Expected throw/strike events are
// queued by the stimulus; a monitor pops and compares them as the DUT pulses.
module tb_delivery_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       bowl_btn = 1'b0;
    logic       swing_btn = 1'b0;
    logic       game_over = 1'b0;
    logic       throw, strike, ball_visible, busy;
    logic [8:0] pixelx;
    logic [7:0] pixely;

    typedef struct {
        bit is_strike;
        int x;
        int y;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  checks = 0;
    int  errors = 0;

    delivery_controller dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .bowl_btn     (bowl_btn),
        .swing_btn    (swing_btn),
        .game_over    (game_over),
        .throw        (throw),
        .strike       (strike),
        .pixelx       (pixelx),
        .pixely       (pixely),
        .ball_visible (ball_visible),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic cyc(input bit t);
        tick = t;
        @(posedge clock);
        #1;
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1);
    endtask

    task automatic push_ev(input bit s, input int x, input int y);
        ev_t e;
        e.is_strike = s;
        e.x = x;
        e.y = y;
        exp_q.push_back(e);
    endtask

    task automatic press_bowl();
        bowl_btn = 1'b1;
        cyc(1'b0);
        bowl_btn = 1'b0;
        cyc(1'b0);
    endtask

    task automatic press_swing();
        swing_btn = 1'b1;
        cyc(1'b0);
        swing_btn = 1'b0;
        cyc(1'b0);
    endtask

    task automatic chk_pos(input string name, input int x, input int y, input int b);
        chk({name, "_x"}, int'(pixelx), x);
        chk({name, "_y"}, int'(pixely), y);
        chk({name, "_busy"}, int'(busy), b);
        chk({name, "_visible"}, int'(ball_visible), b);
    endtask

    // Monitor: every throw/strike pulse must match the head of the queue
    always @(negedge clock) begin
        if (!reset && (throw || strike)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: throw=%0d strike=%0d x=%0d y=%0d, required no event",
                         throw, strike, pixelx, pixely);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_strike", int'(strike), int'(mon_e.is_strike));
                chk("event_throw", int'(throw), int'(!mon_e.is_strike));
                if (mon_e.is_strike) begin
                    chk("strike_x", int'(pixelx), mon_e.x);
                    chk("strike_y", int'(pixely), mon_e.y);
                end
            end
        end
    end

    initial begin
        // 1: reset
        repeat (2) @(posedge clock);
        #1;
        chk_pos("reset", 160, 20, 0);
        chk("reset_throw", int'(throw), 0);
        chk("reset_strike", int'(strike), 0);
        reset = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        chk_pos("idle", 160, 20, 0);

        // 2: bowl, no swing -> miss after 180 ticks
        push_ev(1'b0, 0, 0);
        press_bowl();
        chk_pos("bowl_start", 160, 20, 1);
        push_ev(1'b1, 6, 200);
        ticks(179);
        chk_pos("miss_pre", 160, 199, 1);
        ticks(1);
        chk_pos("miss_land", 6, 200, 1);
        ticks(29);
        chk_pos("miss_hold", 6, 200, 1);
        ticks(1);
        chk_pos("miss_idle", 160, 20, 0);
        chk("miss_pending", exp_q.size(), 0);

        // 3: swing at y=192 coinciding with a tick -> o=7, land (104,136)
        push_ev(1'b0, 0, 0);
        press_bowl();
        ticks(172);
        chk("hit_swing_y", int'(pixely), 192);
        push_ev(1'b1, 104, 136);
        swing_btn = 1'b1;
        cyc(1'b1);
        swing_btn = 1'b0;
        ticks(8);
        chk_pos("hit_land", 104, 136, 1);
        cyc(1'b0);
        chk_pos("hit_frozen", 104, 136, 1);
        ticks(30);
        chk_pos("hit_idle", 160, 20, 0);
        chk("hit_pending", exp_q.size(), 0);

        // 4: early swing at 150 locks out the later in-window swing
        push_ev(1'b0, 0, 0);
        press_bowl();
        ticks(130);
        chk("early_y", int'(pixely), 150);
        press_swing();
        ticks(42);
        chk("late_y", int'(pixely), 192);
        press_swing();
        ticks(7);
        chk_pos("early_pre", 160, 199, 1);
        push_ev(1'b1, 6, 200);
        ticks(1);
        chk_pos("early_miss", 6, 200, 1);
        ticks(30);
        chk_pos("early_idle", 160, 20, 0);
        chk("early_pending", exp_q.size(), 0);

        // 5: game_over abort at y=100, then bowl blocked
        push_ev(1'b0, 0, 0);
        press_bowl();
        ticks(80);
        chk("abort_y", int'(pixely), 100);
        game_over = 1'b1;
        cyc(1'b0);
        chk_pos("abort", 160, 20, 0);
        press_bowl();
        ticks(3);
        chk_pos("blocked", 160, 20, 0);
        game_over = 1'b0;
        cyc(1'b0);
        chk("abort_pending", exp_q.size(), 0);

        // 6: held bowl button does not retrigger; reset mid-flight
        push_ev(1'b0, 0, 0);
        bowl_btn = 1'b1;
        cyc(1'b0);
        push_ev(1'b1, 6, 200);
        ticks(210);
        chk_pos("held_idle", 160, 20, 0);
        repeat (5) cyc(1'b0);
        chk_pos("held_no_rethrow", 160, 20, 0);
        bowl_btn = 1'b0;
        cyc(1'b0);
        push_ev(1'b0, 0, 0);
        press_bowl();
        ticks(172);
        press_swing();
        ticks(3);
        chk("flight_busy", int'(busy), 1);
        reset = 1'b1;
        cyc(1'b0);
        chk_pos("reset_flight", 160, 20, 0);
        chk("reset_flight_strike", int'(strike), 0);
        reset = 1'b0;
        ticks(10);
        chk_pos("post_reset", 160, 20, 0);
        chk("final_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
